pcie_bar_regfile_ring: RTL and testbench

Parametrised PCIe BAR1 register file, successor to the fixed 16-buffer/8-DAC register block. Decodes PIO reads and writes from the PCIe PIO engine and drives the DMA engine, DAC and chopper control registers. Adds an internal DMA buffer ring:
- write index advanced by the DMA engine;
- read index written by the host;
- fill level, overflow detection and an overflow counter.
Reads are registered with 1-cycle latency; the register-write strobe and DAC update strobes are single-cycle pulses.

---
 rtl/pcie_bar_regfile_ring_pkg.sv | 33 +++
 rtl/pcie_bar_regfile_ring_ctrl.sv | 49 ++++
 rtl/pcie_bar_regfile_ring.sv | 159 +++++++++++++++
 tb/tb_pcie_bar_regfile_ring.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pcie_bar_regfile_ring_pkg.sv
// Shared BAR1 register map, bank selects and helpers for the ADC DAQ PCIe slice.
package ADC_DAQ_pkg;

  typedef enum logic [7:0] {
    STATUS_a      = 8'h00,
    COMMAND_a     = 8'h01,
    WR_IDX_a      = 8'h02,
    TIME_CNT_a    = 8'h03,
    N_BYTES_a     = 8'h04,
    REG_OFFSET_a  = 8'h05,
    REG_DATA_a    = 8'h06,
    CHOP_MAX_a    = 8'h07,
    CHOP_CHANGE_a = 8'h08,
    RING_RD_IDX_a = 8'h09,
    RING_CTRL_a   = 8'h0A
  } bar1_off_e;

  localparam int unsigned DMA_BUFF_BASE_a = 32'h10;
  localparam int unsigned DAC_BASE_a      = 32'h40;

  localparam logic [2:0] BAR0_SEL  = 3'b000;
  localparam logic [2:0] BAR1_10_8 = 3'b001;

  localparam int unsigned OVF_CNT_W = 16;

  localparam logic [15:0] DEF_FILL     = 16'h0001;
  localparam logic [31:0] BAR0_PATTERN = 32'h5500_0000;

  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/pcie_bar_regfile_ring_ctrl.sv
// DMA buffer ring: write index advanced by the DMA engine, read index set by the host.
module pcie_dma_ring_ctrl
  import ADC_DAQ_pkg::*;
#(
  parameter int unsigned N_DMA_BUF = 16,
  parameter int unsigned IDX_W     = $clog2(N_DMA_BUF)
) (
  input  logic                 trn_clk,
  input  logic                 pio_reset,
  input  logic                 done,
  input  logic                 enable,
  input  logic                 rd_idx_wr,
  input  logic [IDX_W-1:0]     rd_idx_wdata,
  input  logic                 clear,
  output logic [IDX_W-1:0]     wr_idx,
  output logic [IDX_W-1:0]     rd_idx,
  output logic [IDX_W-1:0]     fill,
  output logic                 full,
  output logic                 ovf_flag,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);

  // Power-of-2 ring: natural wrap of the index width gives the modulo.
  assign fill = wr_idx - rd_idx;
  assign full = &fill;

  always_ff @(posedge trn_clk) begin
    if (pio_reset) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      ovf_flag <= 1'b0;
      ovf_cnt  <= '0;
    end else begin
      if (rd_idx_wr)
        rd_idx <= rd_idx_wdata;
      if (done && enable && !full)
        wr_idx <= wr_idx + 1'b1;
      if (clear) begin
        ovf_flag <= 1'b0;
        ovf_cnt  <= '0;
      end else if (done && enable && full) begin
        ovf_flag <= 1'b1;
        if (ovf_cnt != '1)
          ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_bar_regfile_ring.sv
// BAR1 PIO register file: DMA control with buffer ring, indirect registers, DACs, chopper.
module pcie_bar_regfile_ring
  import ADC_DAQ_pkg::*;
#(
  parameter int unsigned N_DMA_BUF  = 16,
  parameter int unsigned N_DAC      = 8,
  parameter int unsigned DAC_W      = 16,
  parameter int unsigned ADDR_W     = 11,
  parameter logic [2:0]  BAR1_SEL   = BAR1_10_8,
  parameter bit          SWAP_BYTES = 1'b1,
  parameter logic [31:0] DAC_RST    = '0
) (
  input  logic                   trn_clk,
  input  logic                   pio_reset,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [31:0]            rd_data,
  output logic                   rd_valid,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [31:0]            wr_data,
  output logic                   wr_busy,
  output logic [31:0]            command,
  output logic [24:0]            dma_size,
  output logic [29:0]            dma_host_addr,
  output logic [4:0]             dma_curr_buf,
  input  logic                   dma_buf_done,
  output logic                   dma_ring_full,
  input  logic [31:0]            time_counter,
  input  logic [31:0]            status,
  output logic [15:0]            reg_offset,
  output logic [31:0]            reg_data,
  output logic                   reg_wrt_en,
  output logic [N_DAC*DAC_W-1:0] dac_data,
  output logic [N_DAC-1:0]       dac_upd,
  output logic [31:0]            chop_max_count,
  output logic [31:0]            chop_change_count
);

  localparam int unsigned IDX_W = $clog2(N_DMA_BUF);

  logic [31:0]          wd;
  logic [2:0]           wr_bank, rd_bank;
  logic [7:0]           wr_off, rd_off;
  logic                 wr_hit;
  logic [29:0]          desc [N_DMA_BUF];
  logic [IDX_W-1:0]     wr_idx, rd_idx, fill;
  logic                 full, ovf_flag;
  logic [OVF_CNT_W-1:0] ovf_cnt;
  logic [31:0]          rd_raw;

  assign wd      = SWAP_BYTES ? byte_swap(wr_data) : wr_data;
  assign wr_bank = wr_addr[ADDR_W-1 -: 3];
  assign rd_bank = rd_addr[ADDR_W-1 -: 3];
  assign wr_off  = wr_addr[7:0];
  assign rd_off  = rd_addr[7:0];
  assign wr_hit  = wr_en && (wr_bank == BAR1_SEL);

  pcie_dma_ring_ctrl #(.N_DMA_BUF(N_DMA_BUF), .IDX_W(IDX_W)) u_ring (
    .trn_clk      (trn_clk),
    .pio_reset    (pio_reset),
    .done         (dma_buf_done),
    .enable       (command[31]),
    .rd_idx_wr    (wr_hit && (wr_off == RING_RD_IDX_a)),
    .rd_idx_wdata (wd[IDX_W-1:0]),
    .clear        (wr_hit && (wr_off == RING_CTRL_a) && wd[0]),
    .wr_idx       (wr_idx),
    .rd_idx       (rd_idx),
    .fill         (fill),
    .full         (full),
    .ovf_flag     (ovf_flag),
    .ovf_cnt      (ovf_cnt)
  );

  assign dma_curr_buf  = 5'(wr_idx);
  assign dma_ring_full = full;
  assign dma_host_addr = desc[wr_idx];

  always_ff @(posedge trn_clk) begin
    if (pio_reset) begin
      command           <= '0;
      dma_size          <= '0;
      reg_offset        <= '0;
      reg_data          <= '0;
      chop_max_count    <= 32'd1024;
      chop_change_count <= 32'd512;
      reg_wrt_en        <= 1'b0;
      dac_upd           <= '0;
      wr_busy           <= 1'b0;
      dac_data          <= {N_DAC{DAC_RST[DAC_W-1:0]}};
      for (int unsigned i = 0; i < N_DMA_BUF; i++)
        desc[i] <= '0;
    end else begin
      wr_busy    <= wr_en;
      reg_wrt_en <= wr_hit && (wr_off == REG_DATA_a);
      dac_upd    <= '0;
      if (wr_hit) begin
        case (wr_off)
          COMMAND_a:     command           <= wd;
          N_BYTES_a:     dma_size          <= wd[31:7];
          REG_OFFSET_a:  reg_offset        <= wd[15:0];
          REG_DATA_a:    reg_data          <= wd;
          CHOP_MAX_a:    chop_max_count    <= wd;
          CHOP_CHANGE_a: chop_change_count <= wd;
          default: ;
        endcase
        for (int unsigned i = 0; i < N_DMA_BUF; i++)
          if (wr_off == 8'(DMA_BUFF_BASE_a + i))
            desc[i] <= wd[31:2];
        for (int unsigned i = 0; i < N_DAC; i++)
          if (wr_off == 8'(DAC_BASE_a + i)) begin
            dac_data[i*DAC_W +: DAC_W] <= wd[DAC_W-1:0];
            dac_upd[i]                 <= 1'b1;
          end
      end
    end
  end

  always_comb begin
    rd_raw = 32'(rd_addr);
    if (rd_bank == BAR0_SEL) begin
      rd_raw = BAR0_PATTERN;
    end else if (rd_bank == BAR1_SEL) begin
      rd_raw = {DEF_FILL, 16'h0000} | 32'(rd_addr);
      case (rd_off)
        STATUS_a:      rd_raw = status;
        COMMAND_a:     rd_raw = command;
        WR_IDX_a:      rd_raw = 32'(wr_idx);
        TIME_CNT_a:    rd_raw = time_counter;
        N_BYTES_a:     rd_raw = {dma_size, 7'b0};
        REG_OFFSET_a:  rd_raw = {16'b0, reg_offset};
        REG_DATA_a:    rd_raw = reg_data;
        CHOP_MAX_a:    rd_raw = chop_max_count;
        CHOP_CHANGE_a: rd_raw = chop_change_count;
        RING_RD_IDX_a: rd_raw = 32'(rd_idx);
        RING_CTRL_a:   rd_raw = {ovf_cnt, 9'b0, 5'(fill), ovf_flag, full};
        default: ;
      endcase
      for (int unsigned i = 0; i < N_DMA_BUF; i++)
        if (rd_off == 8'(DMA_BUFF_BASE_a + i))
          rd_raw = {desc[i], 2'b00};
      for (int unsigned i = 0; i < N_DAC; i++)
        if (rd_off == 8'(DAC_BASE_a + i))
          rd_raw = 32'(dac_data[i*DAC_W +: DAC_W]);
    end
  end

  always_ff @(posedge trn_clk) begin
    if (pio_reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= SWAP_BYTES ? byte_swap(rd_raw) : rd_raw;
    end
  end

endmodule

// File: tb/tb_pcie_bar_regfile_ring.sv
// Directed self-checking bench for pcie_bar_regfile_ring (4-entry ring, byte swap on).
module tb_pcie_bar_regfile_ring;

  logic        trn_clk = 1'b0;
  logic        pio_reset;
  logic        rd_en, wr_en, dma_buf_done;
  logic [10:0] rd_addr, wr_addr;
  logic [31:0] wr_data, rd_data, command, reg_data, chop_max_count, chop_change_count;
  logic [31:0] time_counter, status;
  logic        rd_valid, wr_busy, dma_ring_full, reg_wrt_en;
  logic [24:0] dma_size;
  logic [29:0] dma_host_addr;
  logic [4:0]  dma_curr_buf;
  logic [15:0] reg_offset;
  logic [127:0] dac_data;
  logic [7:0]  dac_upd;

  int n_tests = 0;
  int n_fail  = 0;
  int reg_pulses  = 0;
  int dac5_pulses = 0;
  logic [31:0] rdv;

  always #5 trn_clk = ~trn_clk;

  pcie_bar_regfile_ring #(.N_DMA_BUF(4)) dut (
    .trn_clk           (trn_clk),
    .pio_reset         (pio_reset),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_busy           (wr_busy),
    .command           (command),
    .dma_size          (dma_size),
    .dma_host_addr     (dma_host_addr),
    .dma_curr_buf      (dma_curr_buf),
    .dma_buf_done      (dma_buf_done),
    .dma_ring_full     (dma_ring_full),
    .time_counter      (time_counter),
    .status            (status),
    .reg_offset        (reg_offset),
    .reg_data          (reg_data),
    .reg_wrt_en        (reg_wrt_en),
    .dac_data          (dac_data),
    .dac_upd           (dac_upd),
    .chop_max_count    (chop_max_count),
    .chop_change_count (chop_change_count)
  );

  always @(posedge trn_clk) begin
    if (reg_wrt_en) reg_pulses++;
    if (dac_upd[5]) dac5_pulses++;
  end

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic pio_write(input logic [10:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pio_read(input logic [10:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check("rd_valid_hi", 32'(rd_valid), 32'd1);
    d = rd_data;
    tick();
    check("rd_valid_lo", 32'(rd_valid), 32'd0);
  endtask

  task automatic done_pulse();
    dma_buf_done = 1'b1;
    tick();
    dma_buf_done = 1'b0;
  endtask

  initial begin
    pio_reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; dma_buf_done = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    time_counter = 32'h0000_0000; status = 32'hCAFE_0001;
    repeat (3) tick();
    pio_reset = 1'b0;

    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_command", command, 32'h0);
    check("rst_chop_max", chop_max_count, 32'd1024);
    check("rst_chop_chg", chop_change_count, 32'd512);
    check("rst_curr_buf", 32'(dma_curr_buf), 32'd0);
    check("rst_strobes", {23'b0, reg_wrt_en, dac_upd}, 32'h0);

    pio_read(11'h107, rdv); check("rd_chop_max", rdv, 32'h0004_0000);
    pio_read(11'h108, rdv); check("rd_chop_chg", rdv, 32'h0002_0000);
    pio_read(11'h140, rdv); check("rd_dac0", rdv, 32'h0000_0000);
    pio_read(11'h100, rdv); check("rd_status", rdv, 32'h0100_FECA);

    pio_write(11'h113, 32'h7856_3412);
    check("wr_busy_set", 32'(wr_busy), 32'd1);
    tick();
    check("wr_busy_clr", 32'(wr_busy), 32'd0);
    pio_write(11'h101, bswap(32'h8000_0000));
    pio_read(11'h101, rdv); check("rd_command", rdv, 32'h0000_0080);
    repeat (3) done_pulse();
    check("curr_buf_3", 32'(dma_curr_buf), 32'd3);
    check("host_addr_3", 32'(dma_host_addr), 32'h048D_159E);
    check("ring_full", 32'(dma_ring_full), 32'd1);
    pio_read(11'h10A, rdv); check("ring_ctrl_full", rdv, 32'h0D00_0000);

    done_pulse();
    check("curr_buf_hold", 32'(dma_curr_buf), 32'd3);
    pio_read(11'h10A, rdv); check("ring_ctrl_ovf1", rdv, 32'h0F00_0100);

    pio_write(11'h109, bswap(32'd2));
    check("ring_not_full", 32'(dma_ring_full), 32'd0);
    pio_read(11'h10A, rdv); check("ring_ctrl_fill1", rdv, 32'h0600_0100);

    pio_write(11'h109, bswap(32'd0));
    check("ring_full_again", 32'(dma_ring_full), 32'd1);
    dma_buf_done = 1'b1;
    pio_write(11'h109, bswap(32'd1));
    dma_buf_done = 1'b0;
    pio_read(11'h10A, rdv); check("done_rdidx_same", rdv, 32'h0A00_0200);
    pio_read(11'h109, rdv); check("rd_idx_1", rdv, 32'h0100_0000);

    done_pulse();
    check("curr_buf_wrap", 32'(dma_curr_buf), 32'd0);
    check("host_addr_0", 32'(dma_host_addr), 32'h0);
    dma_buf_done = 1'b1;
    pio_write(11'h10A, bswap(32'd1));
    dma_buf_done = 1'b0;
    pio_read(11'h10A, rdv); check("done_clear_same", rdv, 32'h0D00_0000);

    pio_write(11'h109, bswap(32'd0));
    pio_write(11'h101, 32'h0);
    done_pulse();
    check("done_disabled", 32'(dma_curr_buf), 32'd0);

    pio_write(11'h106, 32'hDDCC_BBAA);
    check("reg_wrt_en_hi", 32'(reg_wrt_en), 32'd1);
    check("reg_data", reg_data, 32'hAABB_CCDD);
    tick();
    check("reg_wrt_en_lo", 32'(reg_wrt_en), 32'd0);
    pio_write(11'h145, 32'h3412_0000);
    check("dac_upd_5", 32'(dac_upd), 32'h0000_0020);
    check("dac5_data", 32'(dac_data[5*16 +: 16]), 32'h0000_1234);
    tick();
    check("dac_upd_lo", 32'(dac_upd), 32'h0);
    tick();
    check("reg_pulse_cnt", reg_pulses, 1);
    check("dac5_pulse_cnt", dac5_pulses, 1);

    pio_read(11'h1FF, rdv); check("rd_bar1_undec", rdv, 32'hFF01_0100);
    pio_read(11'h4AB, rdv); check("rd_other_bank", rdv, 32'hAB04_0000);
    pio_read(11'h005, rdv); check("rd_bar0", rdv, 32'h0000_0055);

    rd_en = 1'b1; rd_addr = 11'h107;
    wr_en = 1'b1; wr_addr = 11'h107; wr_data = bswap(32'h0000_0800);
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check("rd_wr_same_old", rd_data, 32'h0004_0000);
    pio_read(11'h107, rdv); check("rd_chop_new", rdv, 32'h0008_0000);

    pio_write(11'h105, bswap(32'h0000_BEEF));
    check("reg_offset", 32'(reg_offset), 32'h0000_BEEF);
    pio_reset = 1'b1;
    pio_write(11'h105, bswap(32'h0000_1111));
    pio_reset = 1'b0;
    check("rst_discard_wr", 32'(reg_offset), 32'h0);
    check("rst_chop_again", chop_max_count, 32'd1024);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
